// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus: source indices, default widths
// and a small modulo-increment helper used by the FIFO pointers and the
// round-robin pointer.
package cdb_arbiter_pkg;

    // Source indices on the common data bus
    localparam int CDB_SRC_ALU    = 0;
    localparam int CDB_SRC_LSB    = 1;
    localparam int CDB_SRC_MUL    = 2;
    localparam int CDB_SRC_NUM    = 3;

    // Default widths and FIFO depth
    localparam int ROB_POS_WID    = 4;
    localparam int CDB_DATA_WID   = 32;
    localparam int CDB_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSB = 2'd1,
        SRC_MUL = 2'd2
    } cdb_src_e;

    // Increment cur, wrapping to zero when it reaches limit
    function automatic int unsigned wrap_inc(input int unsigned cur,
                                             input int unsigned limit);
        int unsigned nxt;
        nxt = 32'd0;
        if ((cur + 32'd1) >= limit) begin
            nxt = 32'd0;
        end else begin
            nxt = cur + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Single-source result FIFO. A push into a full FIFO is refused even if a
// pop happens on the same edge; flush empties it and discards that edge's
// push and pop.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rptr_r];
    assign push_ok_s = push & ~full & ~flush;
    assign pop_ok_s  = pop & ~empty & ~flush;

    // Entry storage: write the accepted tuple at the write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping, cleared by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_r <= PTR_W'(wrap_inc(32'(wptr_r), DEPTH));
            end
            if (pop_ok_s) begin
                rptr_r <= PTR_W'(wrap_inc(32'(rptr_r), DEPTH));
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each result source pushes into its own FIFO and
// a round-robin scheduler pops one head per cycle onto a registered
// broadcast. Rollback drops everything in flight; overflow is sticky until
// reset.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_SRC     = CDB_SRC_NUM,
    parameter int DEPTH     = CDB_FIFO_DEPTH,
    parameter int ROB_POS_W = ROB_POS_WID,
    parameter int DATA_W    = CDB_DATA_WID
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       rollback,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC*ROB_POS_W-1:0] src_rob_pos,
    input  logic [N_SRC*DATA_W-1:0]    src_val,
    input  logic [N_SRC-1:0]           src_jump,
    input  logic [N_SRC*DATA_W-1:0]    src_pc,
    output logic [N_SRC-1:0]           src_full,
    output logic                       cdb_valid,
    output logic [ROB_POS_W-1:0]       cdb_rob_pos,
    output logic [DATA_W-1:0]          cdb_val,
    output logic                       cdb_jump,
    output logic [DATA_W-1:0]          cdb_pc,
    output logic [$clog2(N_SRC)-1:0]   cdb_src,
    output logic                       overflow
);

    localparam int SRC_W   = $clog2(N_SRC);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ROB_POS_W + 1 + 2 * DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Entry layout: {rob_pos, val, jump, pc}, pc in the low bits
    localparam int PC_LSB   = 0;
    localparam int JUMP_BIT = DATA_W;
    localparam int VAL_LSB  = DATA_W + 1;
    localparam int ROB_LSB  = 2 * DATA_W + 1;

    logic [ENTRY_W-1:0] entry_in_s   [N_SRC];
    logic [ENTRY_W-1:0] head_s       [N_SRC];
    logic [CNT_W-1:0]   fifo_count_s [N_SRC];
    logic [N_SRC-1:0]   fifo_full_s;
    logic [N_SRC-1:0]   fifo_empty_s;
    logic [N_SRC-1:0]   push_s;
    logic [N_SRC-1:0]   pop_s;
    logic               grant_found_s;
    logic [SRC_W-1:0]   grant_idx_s;
    logic [SRC_W-1:0]   rr_next_s;
    logic [ENTRY_W-1:0] grant_head_s;
    logic               overflow_hit_s;

    logic               cdb_valid_r;
    logic [ROB_POS_W-1:0] cdb_rob_pos_r;
    logic [DATA_W-1:0]  cdb_val_r;
    logic               cdb_jump_r;
    logic [DATA_W-1:0]  cdb_pc_r;
    logic [SRC_W-1:0]   cdb_src_r;
    logic               overflow_r;
    logic [SRC_W-1:0]   rr_ptr_r;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign entry_in_s[i] = {src_rob_pos[i*ROB_POS_W +: ROB_POS_W],
                                src_val[i*DATA_W +: DATA_W],
                                src_jump[i],
                                src_pc[i*DATA_W +: DATA_W]};
        // Rollback and a stalled pipeline both block every push and pop
        assign push_s[i]   = src_valid[i] & rdy & ~rollback;
        assign pop_s[i]    = grant_found_s & (grant_idx_s == SRC_W'(i)) & rdy & ~rollback;
        assign src_full[i] = (fifo_count_s[i] == DEPTH_C);

        cdb_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_s[i]),
            .pop   (pop_s[i]),
            .flush (rollback),
            .din   (entry_in_s[i]),
            .head  (head_s[i]),
            .full  (fifo_full_s[i]),
            .empty (fifo_empty_s[i]),
            .count (fifo_count_s[i])
        );
    end

    // Round-robin scan: first non-empty FIFO at or after rr_ptr wins
    always_comb begin
        int scan_idx;
        scan_idx      = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = {SRC_W{1'b0}};
        // Walk from the farthest offset down so the nearest one is kept last
        for (int k = N_SRC - 1; k >= 0; k--) begin
            scan_idx      = (int'(rr_ptr_r) + k) % N_SRC;
            grant_idx_s   = fifo_empty_s[scan_idx] ? grant_idx_s : SRC_W'(scan_idx);
            grant_found_s = grant_found_s | ~fifo_empty_s[scan_idx];
        end
    end

    assign grant_head_s   = head_s[grant_idx_s];
    assign rr_next_s      = SRC_W'(wrap_inc(32'(grant_idx_s), N_SRC));
    assign overflow_hit_s = |(push_s & fifo_full_s);

    // Registered broadcast, round-robin pointer and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_r   <= 1'b0;
            cdb_rob_pos_r <= {ROB_POS_W{1'b0}};
            cdb_val_r     <= {DATA_W{1'b0}};
            cdb_jump_r    <= 1'b0;
            cdb_pc_r      <= {DATA_W{1'b0}};
            cdb_src_r     <= {SRC_W{1'b0}};
            overflow_r    <= 1'b0;
            rr_ptr_r      <= {SRC_W{1'b0}};
        end else if (rollback) begin
            cdb_valid_r <= 1'b0;
            rr_ptr_r    <= {SRC_W{1'b0}};
        end else if (rdy) begin
            if (grant_found_s) begin
                cdb_valid_r   <= 1'b1;
                cdb_rob_pos_r <= grant_head_s[ROB_LSB +: ROB_POS_W];
                cdb_val_r     <= grant_head_s[VAL_LSB +: DATA_W];
                cdb_jump_r    <= grant_head_s[JUMP_BIT];
                cdb_pc_r      <= grant_head_s[PC_LSB +: DATA_W];
                cdb_src_r     <= grant_idx_s;
                rr_ptr_r      <= rr_next_s;
            end else begin
                cdb_valid_r <= 1'b0;
            end
            if (overflow_hit_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign cdb_valid   = cdb_valid_r;
    assign cdb_rob_pos = cdb_rob_pos_r;
    assign cdb_val     = cdb_val_r;
    assign cdb_jump    = cdb_jump_r;
    assign cdb_pc      = cdb_pc_r;
    assign cdb_src     = cdb_src_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, overflow,
// rollback, stall and asynchronous reset.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        rollback;
    logic [2:0]  src_valid;
    logic [11:0] src_rob_pos;
    logic [95:0] src_val;
    logic [2:0]  src_jump;
    logic [95:0] src_pc;
    logic [2:0]  src_full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_pos;
    logic [31:0] cdb_val;
    logic        cdb_jump;
    logic [31:0] cdb_pc;
    logic [1:0]  cdb_src;
    logic        overflow;

    int tests_run;
    int tests_failed;
    int next_tag [3];

    cdb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .rollback    (rollback),
        .src_valid   (src_valid),
        .src_rob_pos (src_rob_pos),
        .src_val     (src_val),
        .src_jump    (src_jump),
        .src_pc      (src_pc),
        .src_full    (src_full),
        .cdb_valid   (cdb_valid),
        .cdb_rob_pos (cdb_rob_pos),
        .cdb_val     (cdb_val),
        .cdb_jump    (cdb_jump),
        .cdb_pc      (cdb_pc),
        .cdb_src     (cdb_src),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [3:0] tag, input logic [31:0] val,
                           input logic jump, input logic [31:0] pc);
        src_valid[i]         = 1'b1;
        src_rob_pos[i*4 +: 4] = tag;
        src_val[i*32 +: 32]  = val;
        src_jump[i]          = jump;
        src_pc[i*32 +: 32]   = pc;
    endtask

    task automatic clear_src();
        src_valid = 3'b000;
        src_jump  = 3'b000;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        rdy          = 1'b1;
        rollback     = 1'b0;
        src_valid    = 3'b000;
        src_rob_pos  = 12'h000;
        src_val      = 96'h0;
        src_jump     = 3'b000;
        src_pc       = 96'h0;

        // Reset state
        #3;
        check("rst_valid",    64'(cdb_valid),   64'd0);
        check("rst_src",      64'(cdb_src),     64'd0);
        check("rst_rob",      64'(cdb_rob_pos), 64'd0);
        check("rst_val",      64'(cdb_val),     64'd0);
        check("rst_full",     64'(src_full),    64'd0);
        check("rst_overflow", 64'(overflow),    64'd0);
        #9;
        rst_n = 1'b1;

        // Single ALU result: pushed at edge 1, broadcast after edge 2
        set_src(0, 4'd5, 32'h1234, 1'b1, 32'h80);
        step();
        clear_src();
        check("t1_latency", 64'(cdb_valid), 64'd0);
        step();
        check("t1_valid", 64'(cdb_valid),   64'd1);
        check("t1_rob",   64'(cdb_rob_pos), 64'd5);
        check("t1_val",   64'(cdb_val),     64'h1234);
        check("t1_jump",  64'(cdb_jump),    64'd1);
        check("t1_pc",    64'(cdb_pc),      64'h80);
        check("t1_src",   64'(cdb_src),     64'd0);
        step();
        check("t1_idle",     64'(cdb_valid),   64'd0);
        check("t1_rob_hold", 64'(cdb_rob_pos), 64'd5);

        // Rollback pulse returns the round-robin pointer to ALU
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        check("rb0_valid", 64'(cdb_valid), 64'd0);

        // All sources push whenever not full: order 0,1,2,0,1,2, tags in order
        for (int i = 0; i < 3; i++) next_tag[i] = 1;
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!src_full[i]) begin
                    set_src(i, 4'(next_tag[i]), 32'(100 + next_tag[i]), 1'b0, 32'h0);
                    next_tag[i]++;
                end else begin
                    src_valid[i] = 1'b0;
                end
            end
            step();
            if (c >= 1) begin
                check($sformatf("t2_valid_%0d", c), 64'(cdb_valid),   64'd1);
                check($sformatf("t2_src_%0d", c),   64'(cdb_src),     64'((c - 1) % 3));
                check($sformatf("t2_rob_%0d", c),   64'(cdb_rob_pos), 64'((c - 1) / 3 + 1));
            end
        end
        clear_src();
        check("t2_no_overflow", 64'(overflow), 64'd0);
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        check("t2_rb_full",  64'(src_full),  64'd0);
        check("t2_rb_valid", 64'(cdb_valid), 64'd0);

        // LSB fills with tags 7,8 (ALU keeps the grant busy), third push overflows
        set_src(0, 4'd10, 32'h0, 1'b0, 32'h0);
        set_src(1, 4'd7,  32'h0, 1'b0, 32'h0);
        step();
        check("t3_a_full", 64'(src_full), 64'd0);
        set_src(0, 4'd11, 32'h0, 1'b0, 32'h0);
        set_src(1, 4'd8,  32'h0, 1'b0, 32'h0);
        step();
        clear_src();
        check("t3_b_full", 64'(src_full),    64'b010);
        check("t3_b_src",  64'(cdb_src),     64'd0);
        check("t3_b_rob",  64'(cdb_rob_pos), 64'd10);
        set_src(1, 4'd15, 32'h0, 1'b0, 32'h0);
        step();
        clear_src();
        check("t3_c_overflow", 64'(overflow),    64'd1);
        check("t3_c_src",      64'(cdb_src),     64'd1);
        check("t3_c_rob",      64'(cdb_rob_pos), 64'd7);
        step();
        check("t3_d_src", 64'(cdb_src),     64'd0);
        check("t3_d_rob", 64'(cdb_rob_pos), 64'd11);
        step();
        check("t3_e_src",      64'(cdb_src),     64'd1);
        check("t3_e_rob",      64'(cdb_rob_pos), 64'd8);
        check("t3_e_overflow", 64'(overflow),    64'd1);
        step();
        check("t3_f_idle", 64'(cdb_valid), 64'd0);

        // Fill FIFOs, then rollback while ALU pushes tag 9
        set_src(0, 4'd1, 32'h0, 1'b0, 32'h0);
        set_src(1, 4'd2, 32'h0, 1'b0, 32'h0);
        set_src(2, 4'd3, 32'h0, 1'b0, 32'h0);
        step();
        clear_src();
        check("t4_g_valid", 64'(cdb_valid), 64'd0);
        set_src(1, 4'd6, 32'h0, 1'b0, 32'h0);
        step();
        clear_src();
        check("t4_h_src",  64'(cdb_src),     64'd2);
        check("t4_h_rob",  64'(cdb_rob_pos), 64'd3);
        check("t4_h_full", 64'(src_full),    64'b010);
        rollback = 1'b1;
        set_src(0, 4'd9, 32'h0, 1'b0, 32'h0);
        step();
        rollback = 1'b0;
        clear_src();
        check("t4_rb_valid",    64'(cdb_valid), 64'd0);
        check("t4_rb_full",     64'(src_full),  64'd0);
        check("t4_rb_overflow", 64'(overflow),  64'd1);
        step();
        check("t4_after_valid", 64'(cdb_valid), 64'd0);

        // MUL tag 4, then three stalled cycles with toggling pushes
        set_src(2, 4'd4, 32'h44, 1'b0, 32'h0);
        step();
        clear_src();
        check("t5_push_valid", 64'(cdb_valid), 64'd0);
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c != 1) begin
                set_src(0, 4'd12, 32'h0, 1'b0, 32'h0);
                set_src(1, 4'd13, 32'h0, 1'b0, 32'h0);
            end else begin
                clear_src();
            end
            step();
            check($sformatf("t5_stall_valid_%0d", c), 64'(cdb_valid),   64'd0);
            check($sformatf("t5_stall_rob_%0d", c),   64'(cdb_rob_pos), 64'd3);
            check($sformatf("t5_stall_full_%0d", c),  64'(src_full),    64'd0);
        end
        clear_src();
        rdy = 1'b1;
        step();
        check("t5_resume_valid", 64'(cdb_valid),   64'd1);
        check("t5_resume_src",   64'(cdb_src),     64'd2);
        check("t5_resume_rob",   64'(cdb_rob_pos), 64'd4);
        check("t5_resume_val",   64'(cdb_val),     64'h44);
        step();
        check("t5_drained", 64'(cdb_valid), 64'd0);

        // Asynchronous reset in the middle of a broadcast cycle
        set_src(0, 4'd1, 32'h0, 1'b0, 32'h0);
        set_src(1, 4'd2, 32'h0, 1'b0, 32'h0);
        step();
        set_src(0, 4'd3, 32'h0, 1'b0, 32'h0);
        set_src(1, 4'd5, 32'h0, 1'b0, 32'h0);
        step();
        clear_src();
        check("t6_pre_valid",    64'(cdb_valid), 64'd1);
        check("t6_pre_full",     64'(src_full),  64'b010);
        check("t6_pre_overflow", 64'(overflow),  64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid",    64'(cdb_valid),   64'd0);
        check("t6_async_full",     64'(src_full),    64'd0);
        check("t6_async_overflow", 64'(overflow),    64'd0);
        check("t6_async_rob",      64'(cdb_rob_pos), 64'd0);
        #10;
        rst_n = 1'b1;
        step();
        check("t6_post_valid", 64'(cdb_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
